// File: rtl/input_unit.sv
// rtl/input_unit.sv - user value capture: sw/key synchronizers, key debounce, four-phase req handshake.
module input_unit #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SIGN_EXTEND     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] sw,
  input  logic        key_n,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        waiting
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_RELEASE = 2'd1,
    WAIT_PRESS   = 2'd2,
    DONE         = 2'd3
  } state_t;

  logic             r_key_s1;
  logic             r_key_s2;
  logic [15:0]      r_sw_s1;
  logic [15:0]      r_sw_s2;
  logic             r_key_db;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_data;
  state_t           r_state;
  state_t           w_next;

  logic             w_mismatch;
  logic             w_settle;
  logic             w_press;
  logic             w_capture;
  logic [15:0]      w_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_s1 <= 1'b1;
      r_key_s2 <= 1'b1;
      r_sw_s1  <= 16'h0000;
      r_sw_s2  <= 16'h0000;
    end else begin
      r_key_s1 <= key_n;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // The level flips on the edge where the run of differing cycles would reach
  // DEBOUNCE_CYCLES, so the counter never holds that value and cannot wrap.
  assign w_mismatch = (r_key_s2 != r_key_db);
  assign w_settle   = w_mismatch && (r_cnt == CNT_LAST);
  assign w_press    = w_settle && r_key_db;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_db <= 1'b1;
      r_cnt    <= '0;
    end else if (!w_mismatch) begin
      r_cnt    <= '0;
    end else if (w_settle) begin
      r_key_db <= r_key_s2;
      r_cnt    <= '0;
    end else begin
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A dropped req wins over a press landing on the same edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:         if (req) w_next = r_key_db ? WAIT_PRESS : WAIT_RELEASE;
      WAIT_RELEASE: if (!req) w_next = IDLE; else if (r_key_db) w_next = WAIT_PRESS;
      WAIT_PRESS:   if (!req) w_next = IDLE; else if (w_press) w_next = DONE;
      DONE:         if (!req) w_next = IDLE;
      default:      w_next = IDLE;
    endcase
  end

  assign w_capture = (r_state == WAIT_PRESS) && req && w_press;
  assign w_ext     = (SIGN_EXTEND != 0) ? {16{r_sw_s2[15]}} : 16'h0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= 32'h0000_0000;
    end else if (w_capture) begin
      r_data <= {w_ext, r_sw_s2};
    end
  end

  always_comb begin
    data_valid = (r_state == DONE);
    waiting    = (r_state == WAIT_RELEASE) || (r_state == WAIT_PRESS);
  end

  assign data_out = r_data;

endmodule
